modrm_agu: RTL and testbench

- Parametrised ModR/M decode, effective-address and memory-operand engine for the x86 core.
- Successor to the in-core ModR/M path, generalised to 8/16/32-bit operands via a size input and a configurable physical address width.
- Adds a memory writeback phase for read-modify-write instructions.
- Owns a byte-wide memory port during its phases; the core sequencer starts it and consumes the decoded operand.

---
 rtl/modrm_agu_if.sv | 44 ++++
 rtl/modrm_agu.sv | 211 +++++++++++++++++++++
 tb/tb_modrm_agu.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/modrm_agu_if.sv
// Bus between the core sequencer and the ModR/M address engine: decode
// controls, register/segment inputs, byte memory port and decoded results.
interface modrm_agu_if #(
  parameter int ADDR_W   = 20,
  parameter int OP_BYTES = 2
);
  logic                    start;
  logic [1:0]              size;
  logic                    need_read;
  logic                    ovr;
  logic [15:0]             ovr_seg;
  logic [15:0]             cs, ip;
  logic [15:0]             bx, bp, si, di;
  logic [15:0]             ds, ss;
  logic [ADDR_W-1:0]       address;
  logic [7:0]              data;
  logic [7:0]              out;
  logic                    wren;
  logic                    busy;
  logic                    ready;
  logic [7:0]              modrm;
  logic                    is_reg;
  logic [15:0]             ip_next;
  logic [15:0]             eff;
  logic [15:0]             seg;
  logic [8*OP_BYTES-1:0]   mem_op;
  logic                    wb_start;
  logic [8*OP_BYTES-1:0]   wb_data;
  logic                    wb_done;

  modport master (
    output start, size, need_read, ovr, ovr_seg, cs, ip, bx, bp, si, di, ds, ss,
    output data, wb_start, wb_data,
    input  address, out, wren, busy, ready, modrm, is_reg, ip_next, eff, seg,
    input  mem_op, wb_done
  );

  modport slave (
    input  start, size, need_read, ovr, ovr_seg, cs, ip, bx, bp, si, di, ds, ss,
    input  data, wb_start, wb_data,
    output address, out, wren, busy, ready, modrm, is_reg, ip_next, eff, seg,
    output mem_op, wb_done
  );
endinterface

// File: rtl/modrm_agu.sv
// ModR/M decode, effective-address and memory-operand engine with a
// byte-wide memory port and a writeback phase for read-modify-write ops.
module modrm_agu #(
  parameter int ADDR_W   = 20,
  parameter int OP_BYTES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  modrm_agu_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_MODRM, S_DISP_LO, S_DISP_HI, S_READ, S_DONE, S_WB, S_WB_DONE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_size;
  logic                  r_need_read;
  logic                  r_ovr;
  logic [15:0]           r_ovr_seg;
  logic [15:0]           r_ip_cur;
  logic [7:0]            r_modrm;
  logic                  r_is_reg;
  logic                  r_disp16;
  logic [15:0]           r_eff;
  logic [15:0]           r_seg;
  logic [8*OP_BYTES-1:0] r_mem_op;
  logic [8*OP_BYTES-1:0] r_wb_data;
  logic [1:0]            r_k;
  logic                  r_wren;
  logic [7:0]            r_out;
  logic                  r_ready;
  logic                  r_wb_done;

  logic [1:0]  w_mod;
  logic [2:0]  w_rm;
  logic [15:0] w_base;
  logic [15:0] w_seg_sel;
  logic [1:0]  w_last;
  logic [15:0] w_mem_off;
  logic [15:0] w_aseg;
  logic [15:0] w_aoff;
  logic [7:0]  w_wb_next;

  assign w_mod     = bus.data[7:6];
  assign w_rm      = bus.data[2:0];
  assign w_last    = (r_size == 2'd0) ? 2'd0 :
                     ((r_size == 2'd1) || (OP_BYTES == 2)) ? 2'd1 : 2'd3;
  assign w_mem_off = r_eff + {14'b0, r_k};

  always_comb begin
    w_base = 16'h0000;
    case (w_rm)
      3'd0: w_base = bus.bx + bus.si;
      3'd1: w_base = bus.bx + bus.di;
      3'd2: w_base = bus.bp + bus.si;
      3'd3: w_base = bus.bp + bus.di;
      3'd4: w_base = bus.si;
      3'd5: w_base = bus.di;
      3'd6: w_base = (w_mod == 2'd0) ? 16'h0000 : bus.bp;
      default: w_base = bus.bx;
    endcase
  end

  // bp-based forms default to the stack segment; direct disp16 (mod 00, rm 110) does not
  always_comb begin
    w_seg_sel = bus.ds;
    if (r_ovr)
      w_seg_sel = r_ovr_seg;
    else if ((w_mod != 2'd3) && ((w_rm == 3'd2) || (w_rm == 3'd3)))
      w_seg_sel = bus.ss;
    else if ((w_rm == 3'd6) && ((w_mod == 2'd1) || (w_mod == 2'd2)))
      w_seg_sel = bus.ss;
  end

  always_comb begin
    w_wb_next = 8'h00;
    for (int b = 0; b < OP_BYTES; b++)
      if ((r_k + 2'd1) == 2'(b)) w_wb_next = r_wb_data[8*b +: 8];
  end

  always_comb begin
    w_aseg = bus.cs;
    w_aoff = r_ip_cur;
    if ((r_state == S_READ) || (r_state == S_WB)) begin
      w_aseg = r_seg;
      w_aoff = w_mem_off;
    end
  end

  assign bus.address = ADDR_W'({w_aseg, 4'h0}) + ADDR_W'(w_aoff);
  assign bus.out     = r_out;
  assign bus.wren    = r_wren;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.ready   = r_ready;
  assign bus.modrm   = r_modrm;
  assign bus.is_reg  = r_is_reg;
  assign bus.ip_next = r_ip_cur;
  assign bus.eff     = r_eff;
  assign bus.seg     = r_seg;
  assign bus.mem_op  = r_mem_op;
  assign bus.wb_done = r_wb_done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_size      <= 2'd0;
      r_need_read <= 1'b0;
      r_ovr       <= 1'b0;
      r_ovr_seg   <= 16'h0000;
      r_ip_cur    <= 16'h0000;
      r_modrm     <= 8'h00;
      r_is_reg    <= 1'b0;
      r_disp16    <= 1'b0;
      r_eff       <= 16'h0000;
      r_seg       <= 16'h0000;
      r_mem_op    <= '0;
      r_wb_data   <= '0;
      r_k         <= 2'd0;
      r_wren      <= 1'b0;
      r_out       <= 8'h00;
      r_ready     <= 1'b0;
      r_wb_done   <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_wb_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_size      <= bus.size;
            r_need_read <= bus.need_read;
            r_ovr       <= bus.ovr;
            r_ovr_seg   <= bus.ovr_seg;
            r_ip_cur    <= bus.ip;
            r_mem_op    <= '0;
            r_k         <= 2'd0;
            r_state     <= S_MODRM;
          end else if (bus.wb_start) begin
            r_wb_data <= bus.wb_data;
            r_k       <= 2'd0;
            if (r_is_reg) begin
              r_wb_done <= 1'b1;
              r_state   <= S_WB_DONE;
            end else begin
              r_wren  <= 1'b1;
              r_out   <= bus.wb_data[7:0];
              r_state <= S_WB;
            end
          end
        end
        S_MODRM: begin
          r_modrm  <= bus.data;
          r_ip_cur <= r_ip_cur + 16'd1;
          r_eff    <= w_base;
          r_seg    <= w_seg_sel;
          r_is_reg <= (w_mod == 2'd3);
          r_disp16 <= (w_mod == 2'd2) || ((w_mod == 2'd0) && (w_rm == 3'd6));
          if (w_mod == 2'd3) begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else if ((w_mod != 2'd0) || (w_rm == 3'd6)) begin
            r_state <= S_DISP_LO;
          end else if (r_need_read) begin
            r_state <= S_READ;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DISP_LO, S_DISP_HI: begin
          r_ip_cur <= r_ip_cur + 16'd1;
          if (r_state == S_DISP_HI)
            r_eff <= r_eff + {bus.data, 8'h00};
          else if (r_disp16)
            r_eff <= r_eff + {8'h00, bus.data};
          else
            r_eff <= r_eff + {{8{bus.data[7]}}, bus.data};
          if ((r_state == S_DISP_LO) && r_disp16) begin
            r_state <= S_DISP_HI;
          end else if (r_need_read) begin
            r_state <= S_READ;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          for (int b = 0; b < OP_BYTES; b++)
            if (r_k == 2'(b)) r_mem_op[8*b +: 8] <= bus.data;
          if (r_k == w_last) begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        S_WB: begin
          if (r_k == w_last) begin
            r_wren    <= 1'b0;
            r_out     <= 8'h00;
            r_wb_done <= 1'b1;
            r_state   <= S_WB_DONE;
          end else begin
            r_k   <= r_k + 2'd1;
            r_out <= w_wb_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modrm_agu.sv
// Directed bench for modrm_agu: code bytes come from a small table at cs:ip,
// data bytes elsewhere from an address-derived pattern.
module tb_modrm_agu;
  localparam int ADDR_W   = 20;
  localparam int OP_BYTES = 2;
  localparam logic [19:0] CODE_BASE = 20'h01010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modrm_agu_if #(.ADDR_W(ADDR_W), .OP_BYTES(OP_BYTES)) bus ();
  modrm_agu #(.ADDR_W(ADDR_W), .OP_BYTES(OP_BYTES)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  logic [7:0]  code [4];
  logic [19:0] w_code_off;
  logic [19:0] wr_addr [$];
  logic [7:0]  wr_byte [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_wbd   = 0;
  int lat;

  function automatic logic [7:0] pat(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  assign w_code_off = bus.address - CODE_BASE;
  always_comb begin
    bus.data = pat(bus.address);
    if (w_code_off < 20'd4) bus.data = code[w_code_off[1:0]];
  end

  always @(negedge clk) begin
    if (bus.wren) begin
      wr_addr.push_back(bus.address);
      wr_byte.push_back(bus.out);
    end
    if (bus.wb_done) n_wbd++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [1:0] sz, input logic nr, input logic ov,
                           input logic [15:0] oseg, input logic wbs, output int n);
    @(negedge clk);
    code[0] = b0; code[1] = b1; code[2] = b2; code[3] = 8'h90;
    bus.size = sz; bus.need_read = nr; bus.ovr = ov; bus.ovr_seg = oseg;
    bus.wb_start = wbs; bus.wb_data = 16'hAAAA;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wb_start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  task automatic do_wb(input logic [15:0] d, output int n);
    @(negedge clk);
    bus.wb_data = d; bus.wb_start = 1'b1;
    @(posedge clk); #1;
    bus.wb_start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.wb_done && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 0; bus.size = 0; bus.need_read = 0; bus.ovr = 0; bus.ovr_seg = 0;
    bus.cs = 16'h0100; bus.ip = 16'h0010;
    bus.bx = 16'h0200; bus.bp = 16'h1000; bus.si = 16'h0030; bus.di = 16'h0040;
    bus.ds = 16'h1000; bus.ss = 16'h2000;
    bus.wb_start = 0; bus.wb_data = 0;
    code[0] = 0; code[1] = 0; code[2] = 0; code[3] = 0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_wren", bus.wren, 0);
    check("rst_is_reg", bus.is_reg, 0);
    check("rst_eff", bus.eff, 0);
    check("rst_mem_op", bus.mem_op, 0);
    check("rst_ip_next", bus.ip_next, 0);
    check("rst_modrm", bus.modrm, 0);
    rst_n = 1'b1;

    // register operand
    do_decode(8'hC3, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 16'h0, 1'b0, lat);
    check("c3_lat", lat, 2);
    check("c3_is_reg", bus.is_reg, 1);
    check("c3_modrm", bus.modrm, 8'hC3);
    check("c3_ip_next", bus.ip_next, 16'h0011);
    check("c3_mem_op", bus.mem_op, 0);
    @(negedge clk);
    check("c3_ready_pulse", bus.ready, 0);
    check("c3_busy_after", bus.busy, 0);
    do_wb(16'h1234, lat);
    check("c3_wb_lat", lat, 1);
    check("c3_wb_writes", wr_addr.size(), 0);

    // bp+disp8 via ss, 16-bit read
    do_decode(8'h46, 8'hFE, 8'h00, 2'd1, 1'b1, 1'b0, 16'h0, 1'b0, lat);
    check("c46_lat", lat, 5);
    check("c46_eff", bus.eff, 16'h0FFE);
    check("c46_seg", bus.seg, 16'h2000);
    check("c46_mem_op", bus.mem_op, {pat(20'h20FFF), pat(20'h20FFE)});
    check("c46_ip_next", bus.ip_next, 16'h0012);
    check("c46_is_reg", bus.is_reg, 0);

    do_wb(16'hBEEF, lat);
    check("wb_lat", lat, 3);
    check("wb_count", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("wb0_addr", wr_addr[0], 20'h20FFE);
      check("wb0_byte", wr_byte[0], 8'hEF);
      check("wb1_addr", wr_addr[1], 20'h20FFF);
      check("wb1_byte", wr_byte[1], 8'hBE);
    end
    @(negedge clk);
    check("wb_done_pulse", bus.wb_done, 0);

    // direct disp16 with override, no read
    do_decode(8'h06, 8'h34, 8'h12, 2'd1, 1'b0, 1'b1, 16'h3000, 1'b0, lat);
    check("c06_lat", lat, 4);
    check("c06_eff", bus.eff, 16'h1234);
    check("c06_seg", bus.seg, 16'h3000);
    check("c06_ip_next", bus.ip_next, 16'h0013);
    check("c06_mem_op", bus.mem_op, 0);

    // bp+si+disp16 defaults to ss
    do_decode(8'h92, 8'h00, 8'h80, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, lat);
    check("c92_lat", lat, 4);
    check("c92_eff", bus.eff, 16'h9030);
    check("c92_seg", bus.seg, 16'h2000);

    // offset wrap inside the segment
    bus.si = 16'hFFFF;
    do_decode(8'h04, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 16'h0, 1'b0, lat);
    check("wrap_lat", lat, 4);
    check("wrap_eff", bus.eff, 16'hFFFF);
    check("wrap_seg", bus.seg, 16'h1000);
    check("wrap_mem_op", bus.mem_op, {pat(20'h10000), pat(20'h1FFFF)});
    check("wrap_ip_next", bus.ip_next, 16'h0011);
    bus.si = 16'h0030;

    // byte operand: upper byte zero-filled
    do_decode(8'h07, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 16'h0, 1'b0, lat);
    check("c07_lat", lat, 3);
    check("c07_eff", bus.eff, 16'h0200);
    check("c07_mem_op", bus.mem_op, {8'h00, pat(20'h10200)});

    // start and wb_start together: writeback dropped
    wr_addr.delete(); wr_byte.delete(); n_wbd = 0;
    do_decode(8'h06, 8'h34, 8'h12, 2'd1, 1'b0, 1'b0, 16'h0, 1'b1, lat);
    check("both_lat", lat, 4);
    repeat (4) @(negedge clk);
    check("both_writes", wr_addr.size(), 0);
    check("both_wb_done", n_wbd, 0);

    // reset in READ
    @(negedge clk);
    code[0] = 8'h46; code[1] = 8'hFE;
    bus.size = 2'd1; bus.need_read = 1'b1; bus.ovr = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rr_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rr_busy", bus.busy, 0);
    check("rr_wren", bus.wren, 0);
    check("rr_eff", bus.eff, 0);
    @(negedge clk) rst_n = 1'b1;
    do_decode(8'h06, 8'h34, 8'h12, 2'd1, 1'b0, 1'b1, 16'h3000, 1'b0, lat);
    check("rr_fresh_lat", lat, 4);
    check("rr_fresh_eff", bus.eff, 16'h1234);
    check("rr_fresh_seg", bus.seg, 16'h3000);

    // reset in WB: write stops at once
    wr_addr.delete(); wr_byte.delete();
    @(negedge clk);
    bus.wb_data = 16'h5566; bus.wb_start = 1'b1;
    @(posedge clk); #2;
    bus.wb_start = 1'b0;
    check("rw_wren_before", bus.wren, 1);
    rst_n = 1'b0;
    #1;
    check("rw_wren", bus.wren, 0);
    check("rw_busy", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rw_writes", wr_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
